hazard_control_unit: RTL and testbench

HAZARD_CONTROL_UNIT -- requirements
Module: hazard_control_unit

---
 rtl/hazard_control_unit.sv | 109 ++++++++++
 tb/tb_hazard_control_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline hazard control: load-use stall, mispredict flush, memory freeze
// Optional event counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  IF_ID_SrcReg1,
  input  logic [3:0]  IF_ID_SrcReg2,
  input  logic        IF_ID_Src1Used,
  input  logic        IF_ID_Src2Used,
  input  logic        ID_EX_MemRead,
  input  logic [3:0]  ID_EX_DstReg,
  input  logic        Br_Mispredict,
  input  logic        Mem_Busy,
  output logic        PC_stall,
  output logic        IF_ID_stall,
  output logic        IF_flush,
  output logic        ID_flush,
  output logic        Pipe_freeze,
  output logic [1:0]  hazard_state,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    MEM_WAIT   = 2'b01,
    FLUSH_HOLD = 2'b10,
    ILLEGAL    = 2'b11
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   pending;
  logic   pending_nxt;
  logic   mispredict;
  logic   load_use;

  // The decode instruction is squashed while in FLUSH_HOLD, so its sources are ignored.
  always_comb begin
    load_use = ID_EX_MemRead && (ID_EX_DstReg != 4'h0) && (state != FLUSH_HOLD) &&
               ((IF_ID_Src1Used && (IF_ID_SrcReg1 == ID_EX_DstReg)) ||
                (IF_ID_Src2Used && (IF_ID_SrcReg2 == ID_EX_DstReg)));
    mispredict = Br_Mispredict || pending;
  end

  always_comb begin
    PC_stall    = 1'b0;
    IF_ID_stall = 1'b0;
    IF_flush    = 1'b0;
    ID_flush    = 1'b0;
    Pipe_freeze = 1'b0;
    if (rst) begin
      if (Mem_Busy) begin
        PC_stall    = 1'b1;
        IF_ID_stall = 1'b1;
        Pipe_freeze = 1'b1;
      end else if (mispredict) begin
        IF_flush = 1'b1;
        ID_flush = 1'b1;
      end else if (load_use) begin
        PC_stall    = 1'b1;
        IF_ID_stall = 1'b1;
        ID_flush    = 1'b1;
      end
    end
  end

  // A mispredict seen during a memory freeze is remembered and replayed when the freeze lifts.
  always_comb begin
    state_nxt   = RUN;
    pending_nxt = 1'b0;
    if (Mem_Busy) begin
      state_nxt   = MEM_WAIT;
      pending_nxt = pending || Br_Mispredict;
    end else if (mispredict) begin
      state_nxt = FLUSH_HOLD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= RUN;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
    end
  end

  assign hazard_state = rst ? state : 2'b00;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= 16'h0000;
      flush_cnt <= 16'h0000;
    end else begin
      if (PC_stall && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (IF_flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'h0000;
  assign flush_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - table-driven scoreboard bench for hazard_control_unit
module tb_hazard_control_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  IF_ID_SrcReg1;
  logic [3:0]  IF_ID_SrcReg2;
  logic        IF_ID_Src1Used;
  logic        IF_ID_Src2Used;
  logic        ID_EX_MemRead;
  logic [3:0]  ID_EX_DstReg;
  logic        Br_Mispredict;
  logic        Mem_Busy;
  logic        PC_stall;
  logic        IF_ID_stall;
  logic        IF_flush;
  logic        ID_flush;
  logic        Pipe_freeze;
  logic [1:0]  hazard_state;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  hazard_control_unit dut (
    .clk(clk), .rst(rst),
    .IF_ID_SrcReg1(IF_ID_SrcReg1), .IF_ID_SrcReg2(IF_ID_SrcReg2),
    .IF_ID_Src1Used(IF_ID_Src1Used), .IF_ID_Src2Used(IF_ID_Src2Used),
    .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_DstReg(ID_EX_DstReg),
    .Br_Mispredict(Br_Mispredict), .Mem_Busy(Mem_Busy),
    .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .IF_flush(IF_flush),
    .ID_flush(ID_flush), .Pipe_freeze(Pipe_freeze), .hazard_state(hazard_state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ctl = {PC_stall, IF_ID_stall, IF_flush, ID_flush, Pipe_freeze}
  typedef struct packed {
    logic       rst;
    logic [3:0] sr1;
    logic [3:0] sr2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [3:0] dst;
    logic       br;
    logic       mb;
    logic [4:0] ctl;
    logic [1:0] st;
  } vec_t;

  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11010;
  localparam logic [4:0] C_FLUSH = 5'b00110;
  localparam logic [4:0] C_FRZ   = 5'b11001;
  localparam logic [1:0] S_RUN = 2'b00, S_MW = 2'b01, S_FH = 2'b10;

  vec_t        vecs[$];
  vec_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [15:0] m_stall = 16'h0;
  logic [15:0] m_flush = 16'h0;

  function automatic vec_t mk(logic r, logic [3:0] s1, logic [3:0] s2, logic a1, logic a2,
                              logic m, logic [3:0] d, logic b, logic busy,
                              logic [4:0] c, logic [1:0] s);
    vec_t v;
    v.rst = r; v.sr1 = s1; v.sr2 = s2; v.u1 = a1; v.u2 = a2; v.mr = m; v.dst = d;
    v.br = b; v.mb = busy; v.ctl = c; v.st = s;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst = v.rst; IF_ID_SrcReg1 = v.sr1; IF_ID_SrcReg2 = v.sr2;
    IF_ID_Src1Used = v.u1; IF_ID_Src2Used = v.u2; ID_EX_MemRead = v.mr;
    ID_EX_DstReg = v.dst; Br_Mispredict = v.br; Mem_Busy = v.mb;
  endtask

  task automatic model_edge(input vec_t v);
    if (!v.rst) begin
      m_stall = 16'h0;
      m_flush = 16'h0;
    end else begin
      if (v.ctl[4] && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
      if (v.ctl[2] && m_flush != 16'hFFFF) m_flush = m_flush + 16'd1;
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    vec_t e;
    logic [15:0] es, ef;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    #2;
    e = exp_q.pop_front();
`ifdef HAZARD_PERF_CNT_EN
    es = m_stall; ef = m_flush;
`else
    es = 16'h0; ef = 16'h0;
`endif
    chk($sformatf("v%0d ctl", idx), {27'd0, PC_stall, IF_ID_stall, IF_flush, ID_flush, Pipe_freeze},
        {27'd0, e.ctl});
    chk($sformatf("v%0d state", idx), {30'd0, hazard_state}, {30'd0, e.st});
    chk($sformatf("v%0d stall_cnt", idx), {16'd0, stall_cnt}, {16'd0, es});
    chk($sformatf("v%0d flush_cnt", idx), {16'd0, flush_cnt}, {16'd0, ef});
    @(posedge clk);
    model_edge(e);
  endtask

  initial begin
    vec_t idle;
    idle = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, S_RUN);
    // reset held with every hazard input active
    vecs.push_back(mk(0, 3, 3, 1, 1, 1, 3, 1, 1, C_NONE, S_RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, S_RUN));
    // load-use on src1, then dst=0, unused src, src2 match, no load
    vecs.push_back(mk(1, 3, 0, 1, 0, 1, 3, 0, 0, C_STALL, S_RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, S_RUN));
    vecs.push_back(mk(1, 0, 0, 1, 1, 1, 0, 0, 0, C_NONE, S_RUN));
    vecs.push_back(mk(1, 3, 3, 0, 0, 1, 3, 0, 0, C_NONE, S_RUN));
    vecs.push_back(mk(1, 1, 5, 1, 1, 1, 5, 0, 0, C_STALL, S_RUN));
    vecs.push_back(mk(1, 5, 5, 1, 1, 0, 5, 0, 0, C_NONE, S_RUN));
    // Mem_Busy for 3 cycles with mispredict in the 2nd
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, C_FRZ, S_RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, C_FRZ, S_MW));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, C_FRZ, S_MW));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_FLUSH, S_MW));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, S_FH));
    vecs.push_back(idle);
    // mispredict with load-use, then load-use held through FLUSH_HOLD
    vecs.push_back(mk(1, 7, 0, 1, 0, 1, 7, 1, 0, C_FLUSH, S_RUN));
    vecs.push_back(mk(1, 7, 0, 1, 0, 1, 7, 0, 0, C_NONE, S_FH));
    vecs.push_back(mk(1, 7, 0, 1, 0, 1, 7, 0, 0, C_STALL, S_RUN));
    vecs.push_back(idle);
    // back-to-back mispredicts keep FLUSH_HOLD
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, C_FLUSH, S_RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, C_FLUSH, S_FH));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, S_FH));
    vecs.push_back(idle);
    // Mem_Busy beats mispredict and load-use; pending replays over load-use
    vecs.push_back(mk(1, 2, 0, 1, 0, 1, 2, 1, 1, C_FRZ, S_RUN));
    vecs.push_back(mk(1, 2, 0, 1, 0, 1, 2, 0, 0, C_FLUSH, S_MW));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, S_FH));
    vecs.push_back(idle);
    // load-use on MEM_WAIT exit
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, C_FRZ, S_RUN));
    vecs.push_back(mk(1, 0, 9, 0, 1, 1, 9, 0, 0, C_STALL, S_MW));
    vecs.push_back(idle);
    // reset during MEM_WAIT with pending mispredict
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, C_FRZ, S_RUN));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, C_FRZ, S_MW));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, C_NONE, S_RUN));
    vecs.push_back(idle);
    vecs.push_back(idle);

    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_NONE, S_RUN));
    repeat (2) @(posedge clk);
    for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

`ifdef HAZARD_PERF_CNT_EN
    begin
      vec_t frz;
      frz = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, C_FRZ, S_MW);
      @(negedge clk);
      drive(frz);
      for (int i = 0; i < 65536; i++) begin
        @(posedge clk);
        model_edge(frz);
      end
      @(negedge clk);
      chk("stall_cnt saturated", {16'd0, stall_cnt}, 32'h0000FFFF);
      chk("stall_cnt model sat", {16'd0, stall_cnt}, {16'd0, m_stall});
      @(negedge clk);
      chk("stall_cnt holds", {16'd0, stall_cnt}, 32'h0000FFFF);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
